cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_lru.sv | 24 ++
 rtl/cache_controller.sv | 192 +++++++++++++++++++
 tb/tb_cache_controller.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the 2-way set-associative cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        FILL,
        RESPOND
    } state_t;

    localparam int VD_VALID = 0;
    localparam int VD_DIRTY = 1;

    function automatic int offset_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int set_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_bits, input int sets, input int line_bits);
        return addr_bits - set_bits(sets) - offset_bits(line_bits);
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set replacement bit: holds the way to evict next in each set.
module cache_lru #(
    parameter int SETS  = 1024,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_lru,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_lru
);

    logic [SETS-1:0] r_lru;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_lru <= '0;
        else if (i_upd_en) r_lru[i_upd_idx] <= i_upd_lru;
    end

    assign o_rd_lru = r_lru[i_rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Blocking 2-way set-associative cache controller: one CPU request at a time,
// write-back/write-allocate, external tag/data array with one-cycle read latency.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int SETS            = 1024,
    parameter int WAYS            = 2,
    parameter int CACHE_LINE_SIZE = 32,
    parameter int TAG_WIDTH       = tag_bits(ADDRESS_WIDTH, SETS, CACHE_LINE_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cpu_req,
    input  logic                                  cpu_wen,
    input  logic [ADDRESS_WIDTH-1:0]              cpu_addr,
    input  logic [CACHE_LINE_SIZE-1:0]            cpu_wdata,
    output logic [CACHE_LINE_SIZE-1:0]            cpu_rdata,
    output logic                                  cpu_done,
    output logic                                  mem_req,
    output logic                                  mem_wen,
    output logic [ADDRESS_WIDTH-1:0]              mem_addr,
    output logic [CACHE_LINE_SIZE-1:0]            mem_wdata,
    input  logic [CACHE_LINE_SIZE-1:0]            mem_rdata,
    input  logic                                  mem_ack,
    output logic                                  cm_req,
    output logic [ADDRESS_WIDTH-1:0]              cm_address,
    output logic [CACHE_LINE_SIZE-1:0]            cm_data_in,
    output logic [TAG_WIDTH-1:0]                  cm_tag_in,
    output logic [WAYS-1:0][1:0]                  cm_valid_dirty_in,
    output logic [WAYS-1:0]                       cm_wen_data,
    output logic [WAYS-1:0]                       cm_wen_tag,
    input  logic [WAYS-1:0][CACHE_LINE_SIZE-1:0]  cm_data_out,
    input  logic [WAYS-1:0][TAG_WIDTH-1:0]        cm_tag_out,
    input  logic [WAYS-1:0][1:0]                  cm_valid_dirty_out
);

    localparam int OFF_W = offset_bits(CACHE_LINE_SIZE);
    localparam int SET_W = set_bits(SETS);

    state_t                     r_state, w_next;
    logic [ADDRESS_WIDTH-1:0]   r_addr;
    logic                       r_wen, r_hit, r_way;
    logic [CACHE_LINE_SIZE-1:0] r_wdata, r_fill, r_vline, r_rdata;
    logic [TAG_WIDTH-1:0]       r_vtag;

    logic [TAG_WIDTH-1:0]       w_tag;
    logic [SET_W-1:0]           w_set;
    logic [WAYS-1:0]            w_hit_vec;
    logic                       w_hit, w_hit_way, w_victim, w_victim_dirty, w_lru, w_lru_upd;
    logic [1:0]                 w_vd;

    assign w_tag = r_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign w_set = r_addr[OFF_W +: SET_W];

    always_comb begin
        w_hit_vec = '0;
        for (int w = 0; w < WAYS; w++)
            w_hit_vec[w] = cm_valid_dirty_out[w][VD_VALID] && (cm_tag_out[w] == w_tag);
    end

    assign w_hit     = |w_hit_vec;
    assign w_hit_way = !w_hit_vec[0];
    // Fill empty ways lowest-first before consulting the replacement bit.
    assign w_victim  = !cm_valid_dirty_out[0][VD_VALID] ? 1'b0 :
                       !cm_valid_dirty_out[1][VD_VALID] ? 1'b1 : w_lru;
    assign w_victim_dirty = cm_valid_dirty_out[w_victim][VD_VALID] &&
                            cm_valid_dirty_out[w_victim][VD_DIRTY];
    assign w_lru_upd = (r_state == RESPOND);

    cache_lru #(.SETS(SETS), .IDX_W(SET_W)) u_lru (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_rd_idx  (w_set),
        .o_rd_lru  (w_lru),
        .i_upd_en  (w_lru_upd),
        .i_upd_idx (w_set),
        .i_upd_lru (~r_way)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (cpu_req) w_next = LOOKUP;
            LOOKUP:    w_next = w_hit ? RESPOND : (w_victim_dirty ? WRITEBACK : REFILL);
            WRITEBACK: if (mem_ack) w_next = REFILL;
            REFILL:    if (mem_ack) w_next = FILL;
            FILL:      w_next = RESPOND;
            RESPOND:   w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_hit   <= 1'b0;
            r_way   <= 1'b0;
            r_vtag  <= '0;
            r_vline <= '0;
            r_fill  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (cpu_req) begin
                    r_addr  <= cpu_addr;
                    r_wen   <= cpu_wen;
                    r_wdata <= cpu_wdata;
                end
                LOOKUP: begin
                    r_hit <= w_hit;
                    if (w_hit) begin
                        r_way <= w_hit_way;
                        if (!r_wen) r_rdata <= cm_data_out[w_hit_way];
                    end else begin
                        // Victim is captured so mem_addr/mem_wdata stay stable during writeback.
                        r_way   <= w_victim;
                        r_vtag  <= cm_tag_out[w_victim];
                        r_vline <= cm_data_out[w_victim];
                    end
                end
                REFILL: if (mem_ack) r_fill <= mem_rdata;
                FILL:   if (!r_wen) r_rdata <= r_fill;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_vd           = '0;
        w_vd[VD_VALID] = 1'b1;
        w_vd[VD_DIRTY] = r_wen;
    end

    always_comb begin
        cpu_done          = 1'b0;
        mem_req           = 1'b0;
        mem_wen           = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        cm_req            = 1'b0;
        cm_address        = r_addr;
        cm_data_in        = r_wdata;
        cm_tag_in         = w_tag;
        cm_valid_dirty_in = '0;
        cm_wen_data       = '0;
        cm_wen_tag        = '0;
        case (r_state)
            IDLE: begin
                cm_req     = cpu_req & rst;
                cm_address = cpu_addr;
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = {r_vtag, w_set, {OFF_W{1'b0}}};
                mem_wdata = r_vline;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_addr[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            end
            FILL: begin
                cm_req             = 1'b1;
                cm_wen_data[r_way] = 1'b1;
                cm_wen_tag[r_way]  = 1'b1;
                cm_data_in         = r_wen ? r_wdata : r_fill;
                cm_valid_dirty_in  = {WAYS{w_vd}};
            end
            RESPOND: begin
                cpu_done = 1'b1;
                if (r_wen && r_hit) begin
                    cm_req             = 1'b1;
                    cm_wen_data[r_way] = 1'b1;
                    cm_wen_tag[r_way]  = 1'b1;
                    cm_valid_dirty_in  = {WAYS{w_vd}};
                end
            end
            default: ;
        endcase
    end

    assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench: array and memory models around the controller, plus a
// set-associative reference model that predicts data, latency and memory traffic.
module tb_cache_controller;

    localparam int AW = 32, SETS = 1024, WAYS = 2, LW = 32, TW = 20;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      cpu_req = 1'b0, cpu_wen = 1'b0;
    logic [AW-1:0]             cpu_addr = '0;
    logic [LW-1:0]             cpu_wdata = '0;
    logic [LW-1:0]             cpu_rdata;
    logic                      cpu_done;
    logic                      mem_req, mem_wen;
    logic [AW-1:0]             mem_addr;
    logic [LW-1:0]             mem_wdata;
    logic [LW-1:0]             mem_rdata = '0;
    logic                      mem_ack = 1'b0;
    logic                      cm_req;
    logic [AW-1:0]             cm_address;
    logic [LW-1:0]             cm_data_in;
    logic [TW-1:0]             cm_tag_in;
    logic [WAYS-1:0][1:0]      cm_valid_dirty_in;
    logic [WAYS-1:0]           cm_wen_data, cm_wen_tag;
    logic [WAYS-1:0][LW-1:0]   cm_data_out = '0;
    logic [WAYS-1:0][TW-1:0]   cm_tag_out = '0;
    logic [WAYS-1:0][1:0]      cm_valid_dirty_out = '0;

    always #5 clk = ~clk;

    cache_controller #(.ADDRESS_WIDTH(AW), .SETS(SETS), .WAYS(WAYS), .CACHE_LINE_SIZE(LW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cm_req(cm_req), .cm_address(cm_address), .cm_data_in(cm_data_in), .cm_tag_in(cm_tag_in),
        .cm_valid_dirty_in(cm_valid_dirty_in), .cm_wen_data(cm_wen_data), .cm_wen_tag(cm_wen_tag),
        .cm_data_out(cm_data_out), .cm_tag_out(cm_tag_out), .cm_valid_dirty_out(cm_valid_dirty_out)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] mem_default(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Tag/data array: one-cycle read latency, read-before-write.
    logic [LW-1:0] a_data [SETS][2];
    logic [TW-1:0] a_tag  [SETS][2];
    logic [1:0]    a_vd   [SETS][2];
    int            wr_cnt = 0, lw_way = 0, as_idx;
    logic [1:0]    lw_vd = '0;
    logic [LW-1:0] lw_data = '0;

    always @(posedge clk) begin
        if (cm_req) begin
            as_idx = int'(cm_address[11:2]);
            for (int w = 0; w < 2; w++) begin
                cm_data_out[w]        <= a_data[as_idx][w];
                cm_tag_out[w]         <= a_tag[as_idx][w];
                cm_valid_dirty_out[w] <= a_vd[as_idx][w];
            end
            for (int w = 0; w < 2; w++) begin
                if (cm_wen_data[w]) begin
                    a_data[as_idx][w] = cm_data_in;
                    wr_cnt++;
                    lw_way  = w;
                    lw_data = cm_data_in;
                end
                if (cm_wen_tag[w]) begin
                    a_tag[as_idx][w] = cm_tag_in;
                    a_vd[as_idx][w]  = cm_valid_dirty_in[w];
                    lw_vd            = cm_valid_dirty_in[w];
                end
            end
        end
    end

    // Backing memory with per-transaction ack delay.
    logic [LW-1:0] tb_mem [int unsigned];
    int            dly_wb = 1, dly_rf = 1, mcnt = 0, wb_cnt = 0, rf_cnt = 0;
    logic [AW-1:0] cap_addr = '0, last_wb_addr = '0, last_rf_addr = '0;
    logic [LW-1:0] cap_wdata = '0, last_wb_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            mem_ack = 1'b0;
            mcnt    = 0;
        end else begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                mcnt    = 0;
            end
            if (mem_req) begin
                mcnt++;
                if (mcnt == 1) begin
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                end else begin
                    chk("mem_addr_stable", mem_addr, cap_addr);
                    if (mem_wen) chk("mem_wdata_stable", mem_wdata, cap_wdata);
                end
                if (mcnt >= (mem_wen ? dly_wb : dly_rf)) begin
                    mem_ack = 1'b1;
                    if (mem_wen) begin
                        tb_mem[mem_addr] = mem_wdata;
                        wb_cnt++;
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                    end else begin
                        mem_rdata = tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : mem_default(mem_addr);
                        rf_cnt++;
                        last_rf_addr = mem_addr;
                    end
                end
            end
        end
    end

    // Reference model: cache contents, replacement bits and golden memory.
    bit            m_v [SETS][2];
    bit            m_d [SETS][2];
    logic [TW-1:0] m_tag [SETS][2];
    logic [LW-1:0] m_data [SETS][2];
    bit            m_lru [SETS];
    logic [LW-1:0] g_mem [int unsigned];

    task automatic model_access(input logic [AW-1:0] a, input bit wen, input logic [LW-1:0] wd,
                                output bit hit, output bit wb, output logic [AW-1:0] wba,
                                output logic [LW-1:0] wbd, output logic [LW-1:0] rd);
        int s, way;
        logic [TW-1:0] t;
        logic [AW-1:0] la;
        logic [LW-1:0] line;
        s = int'(a[11:2]); t = a[31:12];
        hit = 0; wb = 0; wba = '0; wbd = '0; rd = '0; way = 0;
        for (int w = 1; w >= 0; w--)
            if (m_v[s][w] && m_tag[s][w] == t) begin hit = 1; way = w; end
        if (hit) begin
            if (wen) begin m_data[s][way] = wd; m_d[s][way] = 1; end
            else rd = m_data[s][way];
        end else begin
            if (!m_v[s][0]) way = 0;
            else if (!m_v[s][1]) way = 1;
            else way = int'(m_lru[s]);
            if (m_v[s][way] && m_d[s][way]) begin
                wb  = 1;
                wba = {m_tag[s][way], a[11:2], 2'b00};
                wbd = m_data[s][way];
                g_mem[wba] = wbd;
            end
            la   = {a[31:2], 2'b00};
            line = g_mem.exists(la) ? g_mem[la] : mem_default(la);
            m_v[s][way] = 1; m_tag[s][way] = t;
            if (wen) begin m_data[s][way] = wd;   m_d[s][way] = 1; end
            else     begin m_data[s][way] = line; m_d[s][way] = 0; rd = line; end
        end
        m_lru[s] = (way == 0);
    endtask

    bit            exp_busy = 0, exp_mem = 0, exp_wb = 0, exp_wen = 0;
    logic [LW-1:0] exp_rdata = '0;
    int            done_cnt = 0;

    // Per-cycle compare against the model's expectations.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_cpu_done", cpu_done, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_cm_req", cm_req, 0);
            chk("rst_cm_wen", {cm_wen_data, cm_wen_tag}, 0);
        end else begin
            if (cpu_done) begin
                done_cnt++;
                chk("unexpected_cpu_done", exp_busy, 1);
                if (exp_busy && !exp_wen) chk("cpu_rdata", cpu_rdata, exp_rdata);
            end
            if (mem_req) begin
                chk("unexpected_mem_req", exp_mem, 1);
                if (mem_wen) chk("unexpected_writeback", exp_wb, 1);
            end
            chk("cm_wen_legal", ($countones(cm_wen_data) <= 1) && (cm_wen_data == cm_wen_tag) &&
                                ((cm_wen_data == '0) || cm_req), 1);
        end
    end

    task automatic do_req(input string nm, input logic [AW-1:0] a, input bit wen,
                          input logic [LW-1:0] wd, input int dwb, input int drf, output int lat);
        bit hit, wb;
        logic [AW-1:0] wba;
        logic [LW-1:0] wbd, rd;
        int wb0, rf0, got;
        model_access(a, wen, wd, hit, wb, wba, wbd, rd);
        exp_rdata = rd; exp_wen = wen; exp_mem = !hit; exp_wb = wb; exp_busy = 1;
        dly_wb = dwb; dly_rf = drf; wb0 = wb_cnt; rf0 = rf_cnt;
        @(negedge clk);
        cpu_req = 1; cpu_wen = wen; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk);
        lat = 0; got = 0;
        while (!got && lat < 300) begin
            #1; lat++;
            if (cpu_done) got = 1;
            else @(posedge clk);
        end
        cpu_req = 0;
        chk({nm, " done_seen"}, got, 1);
        chk({nm, " latency"}, lat, hit ? 2 : 3 + drf + (wb ? dwb : 0));
        chk({nm, " refills"}, rf_cnt - rf0, hit ? 0 : 1);
        chk({nm, " writebacks"}, wb_cnt - wb0, wb);
        if (!hit) chk({nm, " refill_addr"}, last_rf_addr, {a[31:2], 2'b00});
        if (wb) begin
            chk({nm, " wb_addr"}, last_wb_addr, wba);
            chk({nm, " wb_data"}, last_wb_data, wbd);
        end
        @(posedge clk); #1;
        chk({nm, " done_single_cycle"}, cpu_done, 0);
        exp_busy = 0; exp_mem = 0; exp_wb = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat, got, wr0, d0;
        bit hit, wb;
        logic [AW-1:0] wba;
        logic [LW-1:0] wbd, rd;
        for (int s = 0; s < SETS; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                a_vd[s][w] = 2'b00; a_tag[s][w] = '0; a_data[s][w] = '0;
                m_v[s][w] = 0; m_d[s][w] = 0; m_tag[s][w] = '0; m_data[s][w] = '0;
            end
        end
        tb_mem[32'h40] = 32'hCAFE_F00D;
        g_mem[32'h40]  = 32'hCAFE_F00D;

        #2;
        chk("reset_cpu_done", cpu_done, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_cpu_rdata", cpu_rdata, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1;

        do_req("cold_read_40", 32'h40, 0, '0, 1, 3, lat);
        chk("cold_rdata_lit", cpu_rdata, 32'hCAFE_F00D);
        chk("cold_latency_lit", lat, 6);
        chk("cold_fill_way_lit", lw_way, 0);
        chk("cold_fill_vd_lit", lw_vd, 2'b01);

        do_req("hit_read_40", 32'h40, 0, '0, 1, 1, lat);
        chk("hit_latency_lit", lat, 2);

        do_req("write_hit_40", 32'h40, 1, 32'h1234_5678, 1, 1, lat);
        chk("write_hit_vd_lit", lw_vd, 2'b11);
        chk("write_hit_data_lit", lw_data, 32'h1234_5678);

        do_req("read_1040", 32'h1040, 0, '0, 1, 1, lat);
        chk("second_way_lit", lw_way, 1);

        do_req("read_2040", 32'h2040, 0, '0, 2, 2, lat);
        chk("dirty_latency_lit", lat, 7);
        chk("wb_addr_lit", last_wb_addr, 32'h40);
        chk("wb_data_lit", last_wb_data, 32'h1234_5678);

        do_req("reread_40", 32'h40, 0, '0, 1, 1, lat);
        chk("written_back_line_lit", cpu_rdata, 32'h1234_5678);

        do_req("write_miss_3080", 32'h3080, 1, 32'hDEAD_BEEF, 1, 1, lat);
        chk("write_miss_vd_lit", lw_vd, 2'b11);
        chk("write_miss_data_lit", lw_data, 32'hDEAD_BEEF);

        do_req("read_3080", 32'h3080, 0, '0, 1, 1, lat);
        chk("write_miss_readback_lit", cpu_rdata, 32'hDEAD_BEEF);

        // Request held high across three back-to-back hits.
        for (int r = 0; r < 3; r++) model_access(32'h3080, 0, '0, hit, wb, wba, wbd, rd);
        exp_rdata = rd; exp_wen = 0; exp_mem = 0; exp_busy = 1; d0 = done_cnt;
        @(negedge clk);
        cpu_req = 1; cpu_wen = 0; cpu_addr = 32'h3080;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            chk($sformatf("b2b_done_k%0d", k), cpu_done, (k % 3) == 1);
        end
        cpu_req = 0;
        @(posedge clk); #1;
        chk("b2b_done_tail", cpu_done, 0);
        chk("b2b_done_count", done_cnt - d0, 3);
        exp_busy = 0;

        // Reset during the refill wait aborts the request.
        exp_busy = 1; exp_mem = 1; exp_wb = 0; exp_wen = 0; dly_rf = 20;
        wr0 = wr_cnt; d0 = done_cnt;
        @(negedge clk);
        cpu_req = 1; cpu_wen = 0; cpu_addr = 32'h5000;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            if (mem_req) got = 1;
        end
        chk("abort_reached_refill", got, 1);
        @(posedge clk); #2;
        rst = 0;
        #1;
        chk("abort_mem_req_drop", mem_req, 0);
        chk("abort_cm_req_drop", cm_req, 0);
        cpu_req = 0; exp_busy = 0; exp_mem = 0;
        for (int s = 0; s < SETS; s++) m_lru[s] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_array_write", wr_cnt - wr0, 0);
        chk("abort_no_done", done_cnt - d0, 0);

        do_req("post_reset_5000", 32'h5000, 0, '0, 1, 2, lat);
        chk("post_reset_rdata_lit", cpu_rdata, 32'h5A5A_5000);
        chk("post_reset_latency_lit", lat, 5);

        do_req("post_reset_hit_40", 32'h40, 0, '0, 1, 1, lat);
        chk("post_reset_hit_lit", cpu_rdata, 32'h1234_5678);

        do_req("post_reset_1040", 32'h1040, 0, '0, 1, 1, lat);
        chk("post_reset_1040_lit", cpu_rdata, 32'h5A5A_1040);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
